// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM command bus between an SPI slave (priority, one-entry
// holding register) and a parallel host port; MEM_WIDTH must equal ADDR_SIZE.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int MEM_WIDTH    = 8,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] spi_din,
  input  logic                 spi_rx_valid,
  output logic [MEM_WIDTH-1:0] spi_dout,
  output logic                 spi_tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 spi_ovf,
  output logic                 lock_to
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] CMD_WA = 2'b00;
  localparam logic [1:0] CMD_WD = 2'b01;
  localparam logic [1:0] CMD_RA = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SPI_LOCK, SPI_RD_WAIT, HOST_ADDR, HOST_DATA, HOST_WAIT
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_SPI, OWN_HOST} owner_t;

  state_t                 state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic                   pend_q, pend_d;
  logic [CW-1:0]          entry_q, entry_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   h_we_q, h_we_d;
  logic [ADDR_SIZE-1:0]   h_addr_q, h_addr_d;
  logic [MEM_WIDTH-1:0]   h_wdata_q, h_wdata_d;
  logic [CW-1:0]          ram_din_q, ram_din_d;
  logic                   ram_rx_valid_q, ram_rx_valid_d;
  logic                   host_gnt_q, host_gnt_d;
  logic [MEM_WIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic                   spi_ovf_q, spi_ovf_d;
  logic                   lock_to_q, lock_to_d;

  logic consume;
  logic waiting;
  logic timeout;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    pend_d         = pend_q;
    entry_d        = entry_q;
    cnt_d          = cnt_q;
    h_we_d         = h_we_q;
    h_addr_d       = h_addr_q;
    h_wdata_d      = h_wdata_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    host_gnt_d     = 1'b0;
    host_rdata_d   = host_rdata_q;
    host_rvalid_d  = 1'b0;
    spi_ovf_d      = spi_ovf_q;
    lock_to_d      = 1'b0;

    consume = pend_q && (state_q == IDLE || state_q == SPI_LOCK);
    waiting = (state_q == SPI_LOCK) || (state_q == SPI_RD_WAIT) || (state_q == HOST_WAIT);
    timeout = waiting && (cnt_q == TMAX);

    // The SPI side cannot stall: a strobe either lands in the holding register or is lost.
    pend_d = spi_rx_valid || (pend_q && !consume);
    if (spi_rx_valid) begin
      if (!pend_q || consume) entry_d = spi_din;
      else                    spi_ovf_d = 1'b1;
    end

    if (waiting) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE, SPI_LOCK: begin
        if (consume) begin
          ram_din_d      = entry_q;
          ram_rx_valid_d = 1'b1;
          cnt_d          = '0;
          unique case (entry_q[CW-1 -: 2])
            CMD_WA, CMD_RA: state_d = SPI_LOCK;
            CMD_WD:         state_d = IDLE;
            default: begin
              state_d = SPI_RD_WAIT;
              owner_d = OWN_SPI;
            end
          endcase
        end else if (state_q == IDLE && host_req && !spi_rx_valid) begin
          host_gnt_d = 1'b1;
          h_we_d     = host_we;
          h_addr_d   = host_addr;
          h_wdata_d  = host_wdata;
          state_d    = HOST_ADDR;
        end else if (timeout) begin
          state_d   = IDLE;
          lock_to_d = 1'b1;
          owner_d   = OWN_NONE;
        end
      end
      SPI_RD_WAIT: begin
        if (ram_tx_valid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end else if (timeout) begin
          state_d   = IDLE;
          lock_to_d = 1'b1;
          owner_d   = OWN_NONE;
        end
      end
      HOST_ADDR: begin
        ram_din_d      = {h_we_q ? CMD_WA : CMD_RA, h_addr_q};
        ram_rx_valid_d = 1'b1;
        state_d        = HOST_DATA;
      end
      HOST_DATA: begin
        ram_rx_valid_d = 1'b1;
        if (h_we_q) begin
          ram_din_d = {CMD_WD, h_wdata_q};
          state_d   = IDLE;
        end else begin
          ram_din_d = {CMD_RD, {ADDR_SIZE{1'b0}}};
          state_d   = HOST_WAIT;
          owner_d   = OWN_HOST;
          cnt_d     = '0;
        end
      end
      HOST_WAIT: begin
        if (ram_tx_valid) begin
          host_rdata_d  = ram_dout;
          host_rvalid_d = 1'b1;
          state_d       = IDLE;
          owner_d       = OWN_NONE;
        end else if (timeout) begin
          host_rdata_d  = '0;
          host_rvalid_d = 1'b1;
          lock_to_d     = 1'b1;
          state_d       = IDLE;
          owner_d       = OWN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      pend_q         <= 1'b0;
      entry_q        <= '0;
      cnt_q          <= '0;
      h_we_q         <= 1'b0;
      h_addr_q       <= '0;
      h_wdata_q      <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      host_gnt_q     <= 1'b0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      spi_ovf_q      <= 1'b0;
      lock_to_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      pend_q         <= pend_d;
      entry_q        <= entry_d;
      cnt_q          <= cnt_d;
      h_we_q         <= h_we_d;
      h_addr_q       <= h_addr_d;
      h_wdata_q      <= h_wdata_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      host_gnt_q     <= host_gnt_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      spi_ovf_q      <= spi_ovf_d;
      lock_to_q      <= lock_to_d;
    end
  end

  // Read data is steered by whoever issued the last read command; strays go nowhere.
  assign spi_dout     = ram_dout;
  assign spi_tx_valid = ram_tx_valid && (owner_q == OWN_SPI);

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign host_gnt     = host_gnt_q;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign spi_ovf      = spi_ovf_q;
  assign lock_to      = lock_to_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: a RAM model, a golden memory image and an ordered list of
// expected RAM commands, driven by directed scenarios and a randomized transaction mix.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] spi_din;
  logic       spi_rx_valid;
  logic [7:0] spi_dout;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       spi_ovf;
  logic       lock_to;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] gold_mem[256];
  logic [9:0] exp_q[$];
  logic       ram_respond_en;
  logic       stray_req;

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .spi_din      (spi_din),
    .spi_rx_valid (spi_rx_valid),
    .spi_dout     (spi_dout),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .spi_ovf      (spi_ovf),
    .lock_to      (lock_to)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clock(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] cmd);
    spi_din      = cmd;
    spi_rx_valid = 1'b1;
    step_clock(1);
    spi_rx_valid = 1'b0;
  endtask

  // External RAM: latches the address, writes on 01, answers an 11 one cycle later.
  initial begin
    logic       respond;
    logic [7:0] ram_addr;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    ram_addr     = 8'h00;
    forever begin
      @(negedge clk);
      respond = 1'b0;
      if (!rst && ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00, 2'b10: ram_addr = ram_din[7:0];
          2'b01:        ram_mem[ram_addr] = ram_din[7:0];
          default:      respond = ram_respond_en;
        endcase
      end
      @(posedge clk);
      #1;
      ram_tx_valid = respond | stray_req;
      ram_dout     = respond ? ram_mem[ram_addr] : (stray_req ? 8'hAA : 8'h00);
    end
  end

  initial begin
    logic [9:0] exp_cmd;
    forever begin
      @(negedge clk);
      if (!rst && ram_rx_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_cmd", 32'(ram_din), 32'hFFFF_FFFF);
        end else begin
          exp_cmd = exp_q.pop_front();
          check_output("ram_cmd", 32'(ram_din), 32'(exp_cmd));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    int         diffs;
    int         op;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] v;

    rst            = 1'b1;
    spi_din        = '0;
    spi_rx_valid   = 1'b0;
    host_req       = 1'b0;
    host_we        = 1'b0;
    host_addr      = '0;
    host_wdata     = '0;
    ram_respond_en = 1'b1;
    stray_req      = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v           = 8'($urandom);
      ram_mem[i]  = v;
      gold_mem[i] = v;
    end
    ram_mem[8'h55]  = 8'h7E;
    gold_mem[8'h55] = 8'h7E;

    step_clock(2);
    check_output("rst_ram_din", 32'(ram_din), 0);
    check_output("rst_ram_rx_valid", 32'(ram_rx_valid), 0);
    check_output("rst_host_gnt", 32'(host_gnt), 0);
    check_output("rst_host_rvalid", 32'(host_rvalid), 0);
    check_output("rst_spi_ovf", 32'(spi_ovf), 0);
    check_output("rst_lock_to", 32'(lock_to), 0);
    rst = 1'b0;
    step_clock(2);

    // SPI write pair, one cycle from strobe to RAM command
    exp_q.push_back(10'h0A5);
    apply_stimulus(10'h0A5);
    step_clock(1);
    check_output("wp_addr_valid", 32'(ram_rx_valid), 1);
    check_output("wp_addr_din", 32'(ram_din), 32'h0A5);
    step_clock(10);
    exp_q.push_back(10'h13C);
    apply_stimulus(10'h13C);
    step_clock(1);
    check_output("wp_data_valid", 32'(ram_rx_valid), 1);
    check_output("wp_data_din", 32'(ram_din), 32'h13C);
    gold_mem[8'hA5] = 8'h3C;

    // Host read of 0x55
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h55; host_wdata = 8'h00;
    step_clock(1);
    check_output("hr_gnt", 32'(host_gnt), 1);
    host_req = 1'b0;
    exp_q.push_back(10'h255);
    exp_q.push_back(10'h300);
    step_clock(1);
    check_output("hr_gnt_pulse", 32'(host_gnt), 0);
    check_output("hr_addr_din", 32'(ram_din), 32'h255);
    step_clock(1);
    check_output("hr_rd_din", 32'(ram_din), 32'h300);
    step_clock(1);
    check_output("hr_spi_tx_quiet", 32'(spi_tx_valid), 0);
    step_clock(1);
    check_output("hr_rvalid", 32'(host_rvalid), 1);
    check_output("hr_rdata", 32'(host_rdata), 32'h7E);
    step_clock(2);

    // Stray RAM response with no read outstanding
    stray_req = 1'b1;
    step_clock(1);
    stray_req = 1'b0;
    check_output("stray_spi_tx", 32'(spi_tx_valid), 0);
    step_clock(1);
    check_output("stray_host_rvalid", 32'(host_rvalid), 0);
    step_clock(1);

    // Contention: SPI and host in the same cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = 8'h99;
    exp_q.push_back(10'h210);
    apply_stimulus(10'h210);
    check_output("ct_gnt_withheld0", 32'(host_gnt), 0);
    step_clock(1);
    check_output("ct_spi_first", 32'(ram_din), 32'h210);
    exp_q.push_back(10'h300);
    apply_stimulus(10'h300);
    check_output("ct_gnt_withheld1", 32'(host_gnt), 0);
    step_clock(2);
    check_output("ct_spi_tx_valid", 32'(spi_tx_valid), 1);
    check_output("ct_spi_dout", 32'(spi_dout), 32'(gold_mem[8'h10]));
    check_output("ct_host_rvalid", 32'(host_rvalid), 0);
    exp_q.push_back(10'h033);
    exp_q.push_back(10'h199);
    step_clock(2);
    check_output("ct_gnt_late", 32'(host_gnt), 1);
    host_req = 1'b0;
    gold_mem[8'h33] = 8'h99;
    step_clock(3);

    // SPI command arriving while the host address goes out
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h44; host_wdata = 8'h5A;
    step_clock(1);
    check_output("hp_gnt", 32'(host_gnt), 1);
    host_req = 1'b0;
    exp_q.push_back(10'h044);
    exp_q.push_back(10'h15A);
    exp_q.push_back(10'h0C8);
    apply_stimulus(10'h0C8);
    step_clock(1);
    check_output("hp_host_data", 32'(ram_din), 32'h15A);
    step_clock(1);
    check_output("hp_spi_fwd", 32'(ram_din), 32'h0C8);
    check_output("hp_no_ovf", 32'(spi_ovf), 0);
    exp_q.push_back(10'h1D7);
    apply_stimulus(10'h1D7);
    gold_mem[8'h44] = 8'h5A;
    gold_mem[8'hC8] = 8'hD7;
    step_clock(2);

    // Two SPI strobes back to back during a host write
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h66; host_wdata = 8'h11;
    step_clock(1);
    host_req = 1'b0;
    exp_q.push_back(10'h066);
    exp_q.push_back(10'h111);
    exp_q.push_back(10'h0E0);
    apply_stimulus(10'h0E0);
    apply_stimulus(10'h1E1);
    check_output("ov_ovf_set", 32'(spi_ovf), 1);
    step_clock(1);
    check_output("ov_first_kept", 32'(ram_din), 32'h0E0);
    exp_q.push_back(10'h1E1);
    apply_stimulus(10'h1E1);
    gold_mem[8'h66] = 8'h11;
    gold_mem[8'hE0] = 8'hE1;
    step_clock(3);
    check_output("ov_ovf_sticky", 32'(spi_ovf), 1);

    // Abandoned SPI frame: lock released by timeout, then the waiting host is granted
    exp_q.push_back(10'h0F0);
    apply_stimulus(10'h0F0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h77; host_wdata = 8'h22;
    n = 0;
    while (lock_to !== 1'b1 && n < 200) begin
      step_clock(1);
      n++;
    end
    check_output("to_lock_cycles", 32'(n), 65);
    check_output("to_gnt_not_yet", 32'(host_gnt), 0);
    exp_q.push_back(10'h077);
    exp_q.push_back(10'h122);
    step_clock(1);
    check_output("to_gnt_after", 32'(host_gnt), 1);
    check_output("to_lock_pulse", 32'(lock_to), 0);
    host_req = 1'b0;
    gold_mem[8'h77] = 8'h22;
    step_clock(3);

    // Host read that the RAM never answers
    ram_respond_en = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
    step_clock(1);
    host_req = 1'b0;
    exp_q.push_back(10'h212);
    exp_q.push_back(10'h300);
    n = 0;
    while (host_rvalid !== 1'b1 && n < 200) begin
      step_clock(1);
      n++;
    end
    check_output("hto_cycles", 32'(n), 66);
    check_output("hto_lock_to", 32'(lock_to), 1);
    check_output("hto_rdata_zero", 32'(host_rdata), 0);
    ram_respond_en = 1'b1;
    step_clock(2);

    // Reset while the host data command is pending
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h88; host_wdata = 8'h33;
    step_clock(1);
    host_req = 1'b0;
    step_clock(1);
    rst = 1'b1;
    #1;
    check_output("mr_ram_rx_valid", 32'(ram_rx_valid), 0);
    check_output("mr_ram_din", 32'(ram_din), 0);
    check_output("mr_spi_ovf", 32'(spi_ovf), 0);
    check_output("mr_host_rdata", 32'(host_rdata), 0);
    step_clock(2);
    rst = 1'b0;
    step_clock(2);

    // Randomized transaction mix against the golden memory
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 3));
      a  = 8'($urandom);
      d  = 8'($urandom);
      if (op == 0) begin
        exp_q.push_back({2'b00, a});
        apply_stimulus({2'b00, a});
        step_clock(int'($urandom_range(0, 5)));
        exp_q.push_back({2'b01, d});
        apply_stimulus({2'b01, d});
        gold_mem[a] = d;
      end else if (op == 1) begin
        exp_q.push_back({2'b10, a});
        apply_stimulus({2'b10, a});
        step_clock(int'($urandom_range(0, 5)));
        exp_q.push_back({2'b11, d});
        apply_stimulus({2'b11, d});
        n = 0;
        while (spi_tx_valid !== 1'b1 && n < 8) begin
          step_clock(1);
          n++;
        end
        check_output("rnd_spi_tx_seen", 32'(spi_tx_valid), 1);
        check_output("rnd_spi_dout", 32'(spi_dout), 32'(gold_mem[a]));
      end else begin
        host_we = (op == 2); host_addr = a; host_wdata = d; host_req = 1'b1;
        n = 0;
        while (host_gnt !== 1'b1 && n < 8) begin
          step_clock(1);
          n++;
        end
        check_output("rnd_host_gnt", 32'(host_gnt), 1);
        host_req = 1'b0;
        exp_q.push_back({(op == 2) ? 2'b00 : 2'b10, a});
        exp_q.push_back((op == 2) ? {2'b01, d} : 10'h300);
        if (op == 2) begin
          gold_mem[a] = d;
          step_clock(2);
        end else begin
          n = 0;
          while (host_rvalid !== 1'b1 && n < 8) begin
            step_clock(1);
            n++;
          end
          check_output("rnd_host_rvalid", 32'(host_rvalid), 1);
          check_output("rnd_host_rdata", 32'(host_rdata), 32'(gold_mem[a]));
        end
      end
      step_clock(2);
    end

    step_clock(4);
    check_output("end_queue_empty", 32'(exp_q.size()), 0);
    check_output("end_no_ovf", 32'(spi_ovf), 0);
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram_mem[i] !== gold_mem[i]) diffs++;
    end
    check_output("end_mem_image", 32'(diffs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
